shift_sched: RTL and testbench

- Sequencer in front of the ALU barrel shifter. It accepts one decoded shifter-operand op at a time and normalises ARM shift encodings into shifter controls.
- For register-specified shifts it arbitrates for the shared register-file read port to fetch Rs, then issues one registered command.
- Sits between decode and execute and supplies the pipeline stall.

---
 rtl/shift_sched_pkg.sv | 72 +++++++
 rtl/shift_norm.sv | 58 +++++
 rtl/shift_sched.sv | 159 +++++++++++++++
 tb/tb_shift_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sched_pkg.sv
// Shared constants, command struct and immediate-shift helper for shift_sched.
// Register-specified shifts are built only when SHIFT_REG_EN is defined.
package shift_sched_pkg;

  localparam int OP_TYPE_W         = 3;
  localparam int SHIFTER_OPERAND_W = 12;
  localparam int REGAW             = 4;
  localparam int FULLW             = 32;
  localparam int SHIFTCODEW        = 2;
  localparam int WIDTH             = 8;

  localparam logic [OP_TYPE_W-1:0] OP_DATA_SHIFT = 3'd0;
  localparam logic [OP_TYPE_W-1:0] OP_DATA_ROR   = 3'd1;
  localparam logic [OP_TYPE_W-1:0] OP_LDSTR_IMM  = 3'd2;
  localparam logic [OP_TYPE_W-1:0] OP_LDSTR_REG  = 3'd3;

  localparam logic [SHIFTCODEW-1:0] SH_LSL = 2'd0;
  localparam logic [SHIFTCODEW-1:0] SH_LSR = 2'd1;
  localparam logic [SHIFTCODEW-1:0] SH_ASR = 2'd2;
  localparam logic [SHIFTCODEW-1:0] SH_ROR = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RDREQ  = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  localparam int IMM5_MSB     = 11;
  localparam int IMM5_LSB     = 7;
  localparam int CODE_MSB     = 6;
  localparam int CODE_LSB     = 5;
  localparam int RS_MSB       = 11;
  localparam int RS_LSB       = 8;
  localparam int ROT_MSB      = 11;
  localparam int ROT_LSB      = 8;
  localparam int REGSHIFT_BIT = 4;
  localparam int RESERVED_BIT = 7;

  localparam logic [WIDTH-1:0] SHIFT32 = 8'd32;

  typedef struct packed {
    logic [REGAW-1:0]      rm;
    logic [FULLW-1:0]      bypass_rm;
    logic                  should_bypass_rm;
    logic [SHIFTCODEW-1:0] shiftcode;
    logic [WIDTH-1:0]      shiftby;
    logic                  rrx;
    logic                  undef;
  } shift_cmd_t;

  // ARM imm5 quirks: LSR/ASR #0 mean #32, ROR #0 means RRX.
  function automatic shift_cmd_t imm_shift(input logic [SHIFTER_OPERAND_W-1:0] op);
    shift_cmd_t c;
    logic [4:0] imm5;
    c         = '0;
    imm5      = op[IMM5_MSB:IMM5_LSB];
    c.rm      = op[REGAW-1:0];
    c.shiftcode = op[CODE_MSB:CODE_LSB];
    c.shiftby = {3'b000, imm5};
    if (imm5 == 5'd0) begin
      case (op[CODE_MSB:CODE_LSB])
        SH_LSR, SH_ASR: c.shiftby = SHIFT32;
        SH_ROR: begin
          c.rrx     = 1'b1;
          c.shiftby = 8'd1;
        end
        default: c.shiftby = '0;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/shift_norm.sv
// Combinational operand-to-command normaliser shared by the immediate and register paths.
// Register forms are flagged only when SHIFT_REG_EN is defined; otherwise they come out undefined.
module shift_norm
  import shift_sched_pkg::*;
(
  input  logic [OP_TYPE_W-1:0]         optype,
  input  logic [SHIFTER_OPERAND_W-1:0] operand,
`ifdef SHIFT_REG_EN
  input  logic [WIDTH-1:0]             rs_byte,
  output logic                         is_reg,
`endif
  output shift_cmd_t                   cmd
);

  always_comb begin
    cmd = '0;
`ifdef SHIFT_REG_EN
    is_reg = 1'b0;
`endif
    case (optype)
      OP_DATA_SHIFT: begin
        if (!operand[REGSHIFT_BIT]) begin
          cmd = imm_shift(operand);
        end else if (operand[RESERVED_BIT]) begin
          cmd.rm    = operand[REGAW-1:0];
          cmd.undef = 1'b1;
        end else begin
`ifdef SHIFT_REG_EN
          // Rs byte goes through untouched: zero means pass for every code.
          is_reg        = 1'b1;
          cmd.rm        = operand[REGAW-1:0];
          cmd.shiftcode = operand[CODE_MSB:CODE_LSB];
          cmd.shiftby   = rs_byte;
`else
          cmd.rm    = operand[REGAW-1:0];
          cmd.undef = 1'b1;
`endif
        end
      end
      OP_LDSTR_REG: cmd = imm_shift(operand);
      OP_DATA_ROR: begin
        // Rm field is meaningless here since the immediate replaces Rm.
        cmd.bypass_rm        = {24'd0, operand[7:0]};
        cmd.should_bypass_rm = 1'b1;
        if (operand[ROT_MSB:ROT_LSB] != 4'd0) begin
          cmd.shiftcode = SH_ROR;
          cmd.shiftby   = {3'b000, operand[ROT_MSB:ROT_LSB], 1'b0};
        end
      end
      OP_LDSTR_IMM: begin
        cmd.bypass_rm        = {{(FULLW-SHIFTER_OPERAND_W){1'b0}}, operand};
        cmd.should_bypass_rm = 1'b1;
      end
      default: cmd = '0;
    endcase
  end

endmodule

// File: rtl/shift_sched.sv
// Shifter-operand sequencer: normalises ARM shift encodings and fetches Rs for register shifts.
// Define SHIFT_REG_EN to build the register-file read path (RDREQ/RDWAIT).
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int RF_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_TYPE_W-1:0]         in_optype,
  input  logic [SHIFTER_OPERAND_W-1:0] in_operand,
  output logic                         rf_req,
  input  logic                         rf_gnt,
  output logic [REGAW-1:0]             rf_addr,
  input  logic [FULLW-1:0]             rf_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [REGAW-1:0]             out_rm,
  output logic [FULLW-1:0]             out_bypass_rm,
  output logic                         out_should_bypass_rm,
  output logic [SHIFTCODEW-1:0]        out_shiftcode,
  output logic [WIDTH-1:0]             out_shiftby,
  output logic                         out_rrx,
  output logic                         out_undef,
  output logic                         stall,
  output logic [1:0]                   dbg_state
);

  localparam logic [1:0] LAT_M1 = 2'(RF_LAT - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and an offered command/op stays stable until taken.

  logic [1:0]  state_q, state_d;
  shift_cmd_t  cmd_q, cmd_d;
  shift_cmd_t  norm_cmd;
  logic        accept;
  logic [OP_TYPE_W-1:0]         norm_optype;
  logic [SHIFTER_OPERAND_W-1:0] norm_operand;

  assign in_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_OUT) & out_ready));
  assign accept   = in_valid & in_ready;
  assign stall    = in_valid & ~in_ready;

`ifdef SHIFT_REG_EN
  logic [SHIFTER_OPERAND_W-1:0] operand_q, operand_d;
  logic [1:0]                   cnt_q, cnt_d;
  logic                         norm_is_reg;
  logic                         unused_rf;

  // While waiting on Rs the normaliser sees the held op instead of the input port.
  assign norm_optype  = (state_q == ST_RDWAIT) ? OP_DATA_SHIFT : in_optype;
  assign norm_operand = (state_q == ST_RDWAIT) ? operand_q : in_operand;
  assign rf_req       = (state_q == ST_RDREQ);
  assign rf_addr      = rf_req ? operand_q[RS_MSB:RS_LSB] : '0;
  assign unused_rf    = ^rf_data[FULLW-1:WIDTH];

  shift_norm u_norm (
    .optype  (norm_optype),
    .operand (norm_operand),
    .rs_byte (rf_data[WIDTH-1:0]),
    .is_reg  (norm_is_reg),
    .cmd     (norm_cmd)
  );
`else
  logic unused_rf;

  assign norm_optype  = in_optype;
  assign norm_operand = in_operand;
  assign rf_req       = 1'b0;
  assign rf_addr      = '0;
  assign unused_rf    = ^{rf_gnt, rf_data, LAT_M1};

  shift_norm u_norm (
    .optype  (norm_optype),
    .operand (norm_operand),
    .cmd     (norm_cmd)
  );
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
`ifdef SHIFT_REG_EN
    operand_d = operand_q;
    cnt_d     = cnt_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_OUT: begin
          if ((state_q == ST_OUT) && out_ready) state_d = ST_IDLE;
          if (accept) begin
`ifdef SHIFT_REG_EN
            if (norm_is_reg) begin
              state_d   = ST_RDREQ;
              operand_d = in_operand;
            end else
`endif
            begin
              state_d = ST_OUT;
              cmd_d   = norm_cmd;
            end
          end
        end
`ifdef SHIFT_REG_EN
        ST_RDREQ: begin
          if (rf_gnt) begin
            state_d = ST_RDWAIT;
            cnt_d   = LAT_M1;
          end
        end
        ST_RDWAIT: begin
          if (cnt_q == 2'd0) begin
            state_d = ST_OUT;
            cmd_d   = norm_cmd;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
`ifdef SHIFT_REG_EN
      operand_q <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
`ifdef SHIFT_REG_EN
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign out_valid            = (state_q == ST_OUT);
  assign out_rm               = cmd_q.rm;
  assign out_bypass_rm        = cmd_q.bypass_rm;
  assign out_should_bypass_rm = cmd_q.should_bypass_rm;
  assign out_shiftcode        = cmd_q.shiftcode;
  assign out_shiftby          = cmd_q.shiftby;
  assign out_rrx              = cmd_q.rrx;
  assign out_undef            = cmd_q.undef;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: normalisation vectors, back-to-back flow, backpressure,
// flush, async reset and (with SHIFT_REG_EN) the register-file read path.
module tb_shift_sched;
  import shift_sched_pkg::*;

  localparam int RF_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_optype = '0;
  logic [11:0] in_operand = '0;
  logic        rf_req;
  logic        rf_gnt = 1'b0;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_rm;
  logic [31:0] out_bypass_rm;
  logic        out_should_bypass_rm;
  logic [1:0]  out_shiftcode;
  logic [7:0]  out_shiftby;
  logic        out_rrx;
  logic        out_undef;
  logic        stall;
  logic [1:0]  dbg_state;

  shift_sched #(.RF_LAT(RF_LAT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_optype            (in_optype),
    .in_operand           (in_operand),
    .rf_req               (rf_req),
    .rf_gnt               (rf_gnt),
    .rf_addr              (rf_addr),
    .rf_data              (rf_data),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_rm               (out_rm),
    .out_bypass_rm        (out_bypass_rm),
    .out_should_bypass_rm (out_should_bypass_rm),
    .out_shiftcode        (out_shiftcode),
    .out_shiftby          (out_shiftby),
    .out_rrx              (out_rrx),
    .out_undef            (out_undef),
    .stall                (stall),
    .dbg_state            (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] rm, input logic byp_en,
                                     input logic [31:0] byp, input logic [1:0] code,
                                     input logic [7:0] by, input logic rrx, input logic undef);
    return {15'd0, rm, byp, byp_en, code, by, rrx, undef};
  endfunction

  logic [63:0] got_cmd;
  assign got_cmd = {15'd0, out_rm, out_bypass_rm, out_should_bypass_rm,
                    out_shiftcode, out_shiftby, out_rrx, out_undef};

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_spurious_cmd", 64'(exp_q.size()), 64'd1);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_cmd", got_cmd, sb_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one op and return one time unit after the edge that accepted it.
  task automatic send(input logic [2:0] t, input logic [11:0] op);
    int n;
    n = 0;
    in_valid   = 1'b1;
    in_optype  = t;
    in_operand = op;
    #1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("send_timeout", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [2:0] t, input logic [11:0] op,
                         input logic [63:0] e);
    exp_q.push_back(e);
    send(t, op);
    check(tag, got_cmd, e);
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] e_a, e_b;
  int          n;

  initial begin
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),    64'd1);
    check("rst_out_valid", 64'(out_valid),   64'd0);
    check("rst_rf_req",    64'(rf_req),      64'd0);
    check("rst_rf_addr",   64'(rf_addr),     64'd0);
    check("rst_cmd",       got_cmd,          64'd0);
    check("rst_state",     64'(dbg_state),   64'd0);
    #2 rst = 1'b0;
    step();

    // back-to-back immediate issue
    e_a = mk(4'd3, 1'b0, 32'd0, SH_LSR, 8'd32, 1'b0, 1'b0);
    e_b = mk(4'd4, 1'b0, 32'd0, SH_ASR, 8'd3,  1'b0, 1'b0);
    run_vec("b2b_lsr32", OP_DATA_SHIFT, 12'h023, e_a);
    check("b2b_ready", 64'(in_ready), 64'd1);
    run_vec("b2b_asr3",  OP_DATA_SHIFT, 12'h1C4, e_b);
    step();
    check("b2b_drained", 64'(out_valid), 64'd0);

    // normalisation vectors
    run_vec("ror_rrx",      OP_DATA_SHIFT, 12'h061, mk(4'd1, 1'b0, 32'd0,     SH_ROR, 8'd1,  1'b1, 1'b0));
    run_vec("ror_imm31",    OP_DATA_SHIFT, 12'hFE5, mk(4'd5, 1'b0, 32'd0,     SH_ROR, 8'd31, 1'b0, 1'b0));
    run_vec("lsl_pass",     OP_DATA_SHIFT, 12'h009, mk(4'd9, 1'b0, 32'd0,     SH_LSL, 8'd0,  1'b0, 1'b0));
    run_vec("dror_4ff",     OP_DATA_ROR,   12'h4FF, mk(4'd0, 1'b1, 32'hFF,    SH_ROR, 8'd8,  1'b0, 1'b0));
    run_vec("dror_0ab",     OP_DATA_ROR,   12'h0AB, mk(4'd0, 1'b1, 32'hAB,    SH_LSL, 8'd0,  1'b0, 1'b0));
    run_vec("ldst_imm",     OP_LDSTR_IMM,  12'hABC, mk(4'd0, 1'b1, 32'hABC,   SH_LSL, 8'd0,  1'b0, 1'b0));
    run_vec("ldst_reg_asr", OP_LDSTR_REG,  12'h047, mk(4'd7, 1'b0, 32'd0,     SH_ASR, 8'd32, 1'b0, 1'b0));
    run_vec("branch_zero",  3'd4,          12'hFFF, 64'd0);
    run_vec("reserved",     OP_DATA_SHIFT, 12'h09B, mk(4'hB, 1'b0, 32'd0,     SH_LSL, 8'd0,  1'b0, 1'b1));
    step();

`ifdef SHIFT_REG_EN
    // register shift with a withheld grant
    rf_gnt  = 1'b0;
    rf_data = 32'd0;
    exp_q.push_back(mk(4'd2, 1'b0, 32'd0, SH_LSL, 8'h20, 1'b0, 1'b0));
    send(OP_DATA_SHIFT, 12'h512);
    in_valid   = 1'b1;
    in_optype  = OP_DATA_SHIFT;
    in_operand = 12'h080;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rd_req",   64'(rf_req),  64'd1);
      check("rd_addr",  64'(rf_addr), 64'd5);
      check("rd_stall", 64'(stall),   64'd1);
      step();
    end
    rf_gnt  = 1'b1;
    rf_data = 32'h0000_0120;
    step();
    rf_gnt = 1'b0;
    check("rd_req_drop", 64'(rf_req),    64'd0);
    check("rd_wait_nov", 64'(out_valid), 64'd0);
    check("rd_wait_stl", 64'(stall),     64'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("rd_latency", 64'(n),           64'(RF_LAT));
    check("rd_shiftby", 64'(out_shiftby), 64'h20);
    check("rd_rm",      64'(out_rm),      64'd2);
    check("rd_stall_clr", 64'(stall),     64'd0);
    exp_q.push_back(mk(4'd0, 1'b0, 32'd0, SH_LSL, 8'd1, 1'b0, 1'b0));
    step();
    in_valid = 1'b0;
    check("rd_next_op", got_cmd, mk(4'd0, 1'b0, 32'd0, SH_LSL, 8'd1, 1'b0, 1'b0));
    step();

    // flush while waiting for read data
    rf_gnt = 1'b1;
    send(OP_DATA_SHIFT, 12'h312);
    check("fl_addr", 64'(rf_addr), 64'd3);
    step();
    rf_gnt     = 1'b0;
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_optype  = OP_DATA_SHIFT;
    in_operand = 12'h080;
    #1;
    check("fl_state_wait", 64'(dbg_state), 64'(ST_RDWAIT));
    check("fl_in_ready",   64'(in_ready),  64'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_rf_req", 64'(rf_req),    64'd0);
    check("fl_out_v",  64'(out_valid), 64'd0);
    check("fl_idle",   64'(dbg_state), 64'(ST_IDLE));
    for (int i = 0; i < 4; i++) begin
      step();
      check("fl_no_cmd", 64'(out_valid), 64'd0);
    end
`else
    // register form without the read path issues as undefined
    exp_q.push_back(mk(4'd2, 1'b0, 32'd0, SH_LSL, 8'd0, 1'b0, 1'b1));
    send(OP_DATA_SHIFT, 12'h512);
    check("reg_undef",  got_cmd,       mk(4'd2, 1'b0, 32'd0, SH_LSL, 8'd0, 1'b0, 1'b1));
    check("reg_no_req", 64'(rf_req),   64'd0);
    check("reg_addr0",  64'(rf_addr),  64'd0);
    step();
`endif

    // output backpressure with a second op waiting
    out_ready = 1'b0;
    e_a = mk(4'd6, 1'b0, 32'd0, SH_LSR, 8'd5, 1'b0, 1'b0);
    e_b = mk(4'd1, 1'b0, 32'd0, SH_ROR, 8'd2, 1'b0, 1'b0);
    exp_q.push_back(e_a);
    send(OP_DATA_SHIFT, 12'h2A6);
    in_valid   = 1'b1;
    in_optype  = OP_DATA_SHIFT;
    in_operand = 12'h161;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold",     got_cmd,       e_a);
      check("bp_stall",    64'(stall),    64'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 64'(in_ready), 64'd1);
    exp_q.push_back(e_b);
    step();
    in_valid = 1'b0;
    check("bp_second", got_cmd, e_b);
    step();

    // asynchronous reset while holding a command
    out_ready = 1'b0;
    send(OP_DATA_SHIFT, 12'h380);
    check("rs_pre_valid", 64'(out_valid),   64'd1);
    check("rs_pre_by",    64'(out_shiftby), 64'd7);
    #2 rst = 1'b1;
    #1;
    check("rs_async_valid", 64'(out_valid), 64'd0);
    check("rs_async_cmd",   got_cmd,        64'd0);
    check("rs_async_ready", 64'(in_ready),  64'd1);
    step();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    step();
    check("rs_post_valid", 64'(out_valid), 64'd0);
    repeat (2) step();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
